// File: rtl/conv_layer_controller.sv
// Layer sequencer for one convolution layer: one image load, then filter load,
// engine start and output store for each filter.
module conv_layer_controller #(
  parameter int ADDR_W = 16,
  parameter int NF_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] img_size,
  input  logic [ADDR_W-1:0] filt_size,
  input  logic [NF_W-1:0]   num_filters,
  input  logic [ADDR_W-1:0] img_base,
  input  logic [ADDR_W-1:0] filt_base,
  input  logic [ADDR_W-1:0] out_base,
  output logic              load_enable,
  output logic [ADDR_W-1:0] load_size,
  output logic [ADDR_W-1:0] load_addr,
  input  logic              load_done,
  output logic              conv_start,
  input  logic              conv_done,
  output logic              store_enable,
  output logic [ADDR_W-1:0] store_addr,
  output logic [ADDR_W-1:0] store_size,
  input  logic              store_done,
  output logic [NF_W-1:0]   filter_idx,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [3:0] {
    IDLE, SETUP, IMG_ISSUE, IMG_WAIT, FLT_ISSUE, FLT_WAIT,
    CONV_ISSUE, CONV_WAIT, ST_ISSUE, ST_WAIT, NEXT, FINISH
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] filt_size_reg, filt_size_next;
  logic [NF_W-1:0]   nf_reg, nf_next;
  logic [ADDR_W-1:0] osz_reg, osz_next;
  logic [ADDR_W-1:0] fstep_reg, fstep_next;
  logic [ADDR_W-1:0] ostep_reg, ostep_next;
  logic [ADDR_W-1:0] fa_reg, fa_next;
  logic [ADDR_W-1:0] oa_reg, oa_next;

  logic              load_enable_next, conv_start_next, store_enable_next;
  logic [ADDR_W-1:0] load_size_next, load_addr_next, store_addr_next, store_size_next;
  logic [NF_W-1:0]   filter_idx_next;
  logic              busy_next, done_next, error_next;

  logic [ADDR_W-1:0] osz_calc, fstep_calc, ostep_calc;

  // Geometry is derived from the live inputs during SETUP, the cycle they are latched.
  assign osz_calc   = img_size - filt_size + ADDR_W'(1);
  assign fstep_calc = filt_size * filt_size;
  assign ostep_calc = osz_calc * osz_calc;

  always_comb begin
    state_next        = state_reg;
    filt_size_next    = filt_size_reg;
    nf_next           = nf_reg;
    osz_next          = osz_reg;
    fstep_next        = fstep_reg;
    ostep_next        = ostep_reg;
    fa_next           = fa_reg;
    oa_next           = oa_reg;
    load_enable_next  = load_enable;
    load_size_next    = load_size;
    load_addr_next    = load_addr;
    conv_start_next   = 1'b0;
    store_enable_next = store_enable;
    store_addr_next   = store_addr;
    store_size_next   = store_size;
    filter_idx_next   = filter_idx;
    busy_next         = busy;
    done_next         = 1'b0;
    error_next        = error;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SETUP;
          busy_next  = 1'b1;
          error_next = 1'b0;
        end
      end
      SETUP: begin
        filt_size_next  = filt_size;
        nf_next         = num_filters;
        osz_next        = osz_calc;
        fstep_next      = fstep_calc;
        ostep_next      = ostep_calc;
        filter_idx_next = '0;
        fa_next         = filt_base;
        oa_next         = out_base;
        if (filt_size == '0 || filt_size > img_size) begin
          error_next = 1'b1;
          done_next  = 1'b1;
          state_next = FINISH;
        end else if (num_filters == '0) begin
          done_next  = 1'b1;
          state_next = FINISH;
        end else begin
          state_next       = IMG_ISSUE;
          load_enable_next = 1'b1;
          load_addr_next   = img_base;
          load_size_next   = img_size;
        end
      end
      IMG_ISSUE: state_next = IMG_WAIT;
      IMG_WAIT: begin
        // Enable drops here and comes back one cycle later, so load_block
        // always sees a low cycle between the image and first filter request.
        if (load_done) begin
          state_next       = FLT_ISSUE;
          load_enable_next = 1'b0;
          load_addr_next   = fa_reg;
          load_size_next   = filt_size_reg;
        end
      end
      FLT_ISSUE: begin
        state_next       = FLT_WAIT;
        load_enable_next = 1'b1;
      end
      FLT_WAIT: begin
        if (load_done) begin
          state_next       = CONV_ISSUE;
          load_enable_next = 1'b0;
          conv_start_next  = 1'b1;
        end
      end
      CONV_ISSUE: state_next = CONV_WAIT;
      CONV_WAIT: begin
        if (conv_done) begin
          state_next        = ST_ISSUE;
          store_enable_next = 1'b1;
          store_addr_next   = oa_reg;
          store_size_next   = osz_reg;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (store_done) begin
          state_next        = NEXT;
          store_enable_next = 1'b0;
        end
      end
      NEXT: begin
        if (filter_idx == nf_reg - NF_W'(1)) begin
          state_next = FINISH;
          done_next  = 1'b1;
        end else begin
          filter_idx_next  = filter_idx + NF_W'(1);
          fa_next          = fa_reg + fstep_reg;
          oa_next          = oa_reg + ostep_reg;
          state_next       = FLT_ISSUE;
          load_enable_next = 1'b1;
          load_addr_next   = fa_reg + fstep_reg;
          load_size_next   = filt_size_reg;
        end
      end
      FINISH: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      filt_size_reg <= '0;
      nf_reg        <= '0;
      osz_reg       <= '0;
      fstep_reg     <= '0;
      ostep_reg     <= '0;
      fa_reg        <= '0;
      oa_reg        <= '0;
      load_enable   <= 1'b0;
      load_size     <= '0;
      load_addr     <= '0;
      conv_start    <= 1'b0;
      store_enable  <= 1'b0;
      store_addr    <= '0;
      store_size    <= '0;
      filter_idx    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      state_reg     <= state_next;
      filt_size_reg <= filt_size_next;
      nf_reg        <= nf_next;
      osz_reg       <= osz_next;
      fstep_reg     <= fstep_next;
      ostep_reg     <= ostep_next;
      fa_reg        <= fa_next;
      oa_reg        <= oa_next;
      load_enable   <= load_enable_next;
      load_size     <= load_size_next;
      load_addr     <= load_addr_next;
      conv_start    <= conv_start_next;
      store_enable  <= store_enable_next;
      store_addr    <= store_addr_next;
      store_size    <= store_size_next;
      filter_idx    <= filter_idx_next;
      busy          <= busy_next;
      done          <= done_next;
      error         <= error_next;
    end
  end

endmodule

// File: tb/tb_conv_layer_controller.sv
// Directed bench for conv_layer_controller: responders model load/conv/store
// blocks, a monitor logs each request and the main thread compares to tables.
module tb_conv_layer_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] img_size = '0, filt_size = '0, img_base = '0, filt_base = '0, out_base = '0;
  logic [4:0]  num_filters = '0;
  logic        load_enable, conv_start, store_enable, busy, done, error;
  logic [15:0] load_size, load_addr, store_addr, store_size;
  logic [4:0]  filter_idx;
  logic        load_done = 1'b0, conv_done = 1'b0, store_done = 1'b0;

  conv_layer_controller #(.ADDR_W(16), .NF_W(5)) dut (
    .clk(clk), .reset(reset), .start(start),
    .img_size(img_size), .filt_size(filt_size), .num_filters(num_filters),
    .img_base(img_base), .filt_base(filt_base), .out_base(out_base),
    .load_enable(load_enable), .load_size(load_size), .load_addr(load_addr),
    .load_done(load_done), .conv_start(conv_start), .conv_done(conv_done),
    .store_enable(store_enable), .store_addr(store_addr), .store_size(store_size),
    .store_done(store_done), .filter_idx(filter_idx), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Responder controls
  bit load_hold = 0;
  bit inject    = 0;
  int lcnt = 0, scnt = 0, ccnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (load_enable) lcnt++; else lcnt = 0;
      if (store_enable) scnt++; else scnt = 0;
      if (conv_start) ccnt = 1; else if (ccnt != 0) ccnt++;
      if (reset) begin lcnt = 0; scnt = 0; ccnt = 0; end
      load_done  = load_hold || (lcnt == 3);
      store_done = (scnt == 3);
      conv_done  = (ccnt == 3) || (inject && load_enable && load_addr == 16'd100 && lcnt == 1);
      if (ccnt == 3) ccnt = 0;
    end
  end

  // Monitor: 1=load, 2=conv, 3=store
  int ev_kind[32], ev_addr[32], ev_size[32], ev_idx[32];
  int ev_n = 0, done_cnt = 0;
  int load_len[16];
  int nlen = 0, cur_len = 0;
  logic pl = 1'b0, ps = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (ev_n < 32) begin
        if (load_enable && !pl) begin
          ev_kind[ev_n] = 1; ev_addr[ev_n] = int'(load_addr);
          ev_size[ev_n] = int'(load_size); ev_idx[ev_n] = int'(filter_idx); ev_n++;
        end else if (conv_start) begin
          ev_kind[ev_n] = 2; ev_addr[ev_n] = 0; ev_size[ev_n] = 0;
          ev_idx[ev_n] = int'(filter_idx); ev_n++;
        end else if (store_enable && !ps) begin
          ev_kind[ev_n] = 3; ev_addr[ev_n] = int'(store_addr);
          ev_size[ev_n] = int'(store_size); ev_idx[ev_n] = int'(filter_idx); ev_n++;
        end
      end
      if (done) done_cnt++;
      if (load_enable) cur_len++;
      else if (cur_len > 0) begin
        if (nlen < 16) begin load_len[nlen] = cur_len; nlen++; end
        cur_len = 0;
      end
      pl = load_enable;
      ps = store_enable;
    end
  end

  task automatic start_layer(input int img, input int flt, input int nf,
                             input int ib, input int fb, input int ob);
    @(posedge clk); #1;
    img_size = 16'(img); filt_size = 16'(flt); num_filters = 5'(nf);
    img_base = 16'(ib); filt_base = 16'(fb); out_base = 16'(ob);
    ev_n = 0; done_cnt = 0; nlen = 0; cur_len = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit repulse, output int lat);
    lat = -1;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (repulse && k == 4) start = 1'b1;
      if (repulse && k == 5) start = 1'b0;
      if (done) begin lat = k; break; end
    end
    if (lat < 0) check("done_timeout", 0, 1);
  endtask

  task automatic check_seq7(input string tag);
    int ek[7] = '{1, 1, 2, 3, 1, 2, 3};
    int ea[7] = '{0, 100, 0, 200, 109, 0, 216};
    int es[7] = '{6, 3, 0, 4, 3, 0, 4};
    check({tag, "_events"}, ev_n, 7);
    for (int i = 0; i < 7 && i < ev_n; i++) begin
      check($sformatf("%s_kind%0d", tag, i), ev_kind[i], ek[i]);
      if (ek[i] != 2) begin
        check($sformatf("%s_addr%0d", tag, i), ev_addr[i], ea[i]);
        check($sformatf("%s_size%0d", tag, i), ev_size[i], es[i]);
      end
    end
  endtask

  initial begin
    int lat;
    int aborted;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_load_enable", int'(load_enable), 0);
    check("rst_conv_start", int'(conv_start), 0);
    check("rst_store_enable", int'(store_enable), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_load_addr", int'(load_addr), 0);
    @(posedge clk); #1 reset = 1'b0;

    // Two-filter layer
    start_layer(6, 3, 2, 0, 100, 200);
    check("A_busy_after_start", int'(busy), 1);
    wait_done(0, lat);
    check_seq7("A");
    if (ev_n >= 7) begin
      check("A_store0_idx", ev_idx[3], 0);
      check("A_store1_idx", ev_idx[6], 1);
    end
    check("A_first_load_gap", (nlen >= 1) ? load_len[0] : 0, 3);
    @(negedge clk);
    check("A_done_pulses", done_cnt, 1);
    check("A_busy_after_done", int'(busy), 0);
    check("A_load_addr_hold", int'(load_addr), 109);
    check("A_store_addr_hold", int'(store_addr), 216);

    // Zero filters
    start_layer(6, 3, 0, 0, 100, 200);
    wait_done(0, lat);
    check("Z_done_latency", lat, 2);
    check("Z_events", ev_n, 0);
    check("Z_error", int'(error), 0);

    // Filter larger than image
    start_layer(6, 7, 2, 0, 100, 200);
    wait_done(0, lat);
    check("E_done_latency", lat, 2);
    check("E_error_at_done", int'(error), 1);
    check("E_events", ev_n, 0);
    repeat (2) @(negedge clk);
    check("E_error_sticky", int'(error), 1);
    start_layer(4, 2, 1, 10, 20, 30);
    check("E_error_cleared", int'(error), 0);
    wait_done(0, lat);
    check("E2_events", ev_n, 4);
    if (ev_n >= 4) begin
      check("E2_filt_addr", ev_addr[1], 20);
      check("E2_store_size", ev_size[3], 3);
    end

    // load_done held high
    load_hold = 1;
    start_layer(6, 3, 1, 0, 100, 200);
    wait_done(0, lat);
    load_hold = 0;
    check("H_events", ev_n, 4);
    check("H_load_requests", (ev_n >= 2) ? int'(ev_kind[0] == 1 && ev_kind[1] == 1) : 0, 1);
    check("H_img_load_len", (nlen >= 1) ? load_len[0] : 0, 2);

    // Reset during CONV_WAIT of filter 1
    aborted = 0;
    start_layer(6, 3, 2, 0, 100, 200);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ev_n >= 6) begin aborted = 1; break; end
    end
    check("R_reached_conv1", aborted, 1);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    check("R_load_enable", int'(load_enable), 0);
    check("R_store_enable", int'(store_enable), 0);
    check("R_busy", int'(busy), 0);
    check("R_filter_idx", int'(filter_idx), 0);
    check("R_load_addr", int'(load_addr), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start_layer(6, 3, 2, 0, 100, 200);
    wait_done(0, lat);
    check_seq7("R");

    // start re-pulsed while busy and stray conv_done during FLT_WAIT
    inject = 1;
    start_layer(6, 3, 2, 0, 100, 200);
    wait_done(1, lat);
    inject = 0;
    check_seq7("I");
    repeat (3) @(negedge clk);
    check("I_idle_busy", int'(busy), 0);
    check("I_no_extra_events", ev_n, 7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
